inst_mem: RTL and testbench



---
 rtl/inst_mem.sv | 61 ++++++
 tb/tb_inst_mem.sv | 102 ++++++++++
 2 files changed

// File: rtl/inst_mem.sv
// Read-only boot-program instruction memory: byte-organised little-endian image,
// registered word-aligned fetch with one cycle of latency.
module inst_mem #(
    parameter int unsigned DEPTH_WORDS = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] PC,
    output logic [31:0] INST_CODE
);

    localparam int unsigned BYTES = 4 * DEPTH_WORDS;
    localparam int unsigned AW    = $clog2(BYTES);

    // Boot program, lowest word in the low bits.
    localparam logic [127:0] BOOT_IMAGE = {
        32'h0051E233,   // 0x0C or  x4,x3,x5
        32'h003170B3,   // 0x08 and x1,x2,x3
        32'h403402B3,   // 0x04 sub x5,x8,x3
        32'h019806B3    // 0x00 add x13,x16,x25
    };

    logic [7:0]    mem [BYTES];
    logic [AW-1:0] base_addr;
    logic          in_range;
    logic [31:0]   inst_d;
    logic [31:0]   inst_q;

    // Contents are pure constants, so no PC value (even X/Z) can disturb them.
    for (genvar b = 0; b < BYTES; b++) begin : g_rom
        if (b < 16) begin : g_boot
            assign mem[b] = BOOT_IMAGE[8*b +: 8];
        end else begin : g_zero
            assign mem[b] = 8'h00;
        end
    end

    assign base_addr = {PC[AW-1:2], 2'b00};
    assign in_range  = (PC < 32'(BYTES));

    always_comb begin
        inst_d = 32'h0000_0000;
        if (in_range) begin
            inst_d = {mem[{base_addr[AW-1:2], 2'b11}],
                      mem[{base_addr[AW-1:2], 2'b10}],
                      mem[{base_addr[AW-1:2], 2'b01}],
                      mem[base_addr]};
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            inst_q <= 32'h0000_0000;
        end else begin
            inst_q <= inst_d;
        end
    end

    assign INST_CODE = inst_q;

endmodule

// File: tb/tb_inst_mem.sv
// Directed bench for inst_mem: reset, sequential/misaligned/out-of-range fetch,
// latency/hold and asynchronous mid-run reset.
module tb_inst_mem;

    logic        CLK;
    logic        RESET;
    logic [31:0] PC;
    logic [31:0] INST_CODE;

    int n_vec;
    int n_err;

    inst_mem #(.DEPTH_WORDS(32)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .PC        (PC),
        .INST_CODE (INST_CODE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] exp);
        n_vec++;
        assert (INST_CODE === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, INST_CODE, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc_val, input string tag, input logic [31:0] exp);
        PC = pc_val;
        tick();
        check(tag, exp);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RESET = 1'b0;
        PC    = 32'h0;

        // Reset held for two cycles
        #1 check("reset_t0", 32'h0);
        tick(); check("reset_c1", 32'h0);
        tick(); check("reset_c2", 32'h0);

        @(negedge CLK);
        RESET = 1'b1;
        #1 check("release_no_clk", 32'h0);

        // Sequential fetch
        fetch(32'd0,  "seq_pc0",  32'h019806B3);
        fetch(32'd4,  "seq_pc4",  32'h403402B3);
        fetch(32'd8,  "seq_pc8",  32'h003170B3);
        fetch(32'd12, "seq_pc12", 32'h0051E233);

        // Misaligned
        fetch(32'd5,  "misalign_pc5",  32'h403402B3);
        fetch(32'd14, "misalign_pc14", 32'h0051E233);
        fetch(32'd3,  "misalign_pc3",  32'h019806B3);

        // Unused and out-of-range
        fetch(32'd16,         "unused_pc16",   32'h0);
        fetch(32'd0,          "back_pc0",      32'h019806B3);
        fetch(32'd124,        "last_word",     32'h0);
        fetch(32'd8,          "back_pc8",      32'h003170B3);
        fetch(32'd128,        "oor_pc128",     32'h0);
        fetch(32'd4,          "back_pc4",      32'h403402B3);
        fetch(32'd132,        "oor_pc132",     32'h0);
        fetch(32'd12,         "back_pc12",     32'h0051E233);
        fetch(32'hFFFF_FFFC,  "oor_pc_max",    32'h0);

        // Latency and hold: PC changes between edges
        fetch(32'd0, "hold_pc0", 32'h019806B3);
        @(negedge CLK);
        PC = 32'd4;
        #1 check("hold_mid", 32'h019806B3);
        tick(); check("hold_next", 32'h403402B3);

        // Mid-run asynchronous reset
        fetch(32'd8, "midrst_pre", 32'h003170B3);
        #2 RESET = 1'b0;
        #1 check("midrst_async", 32'h0);
        tick(); check("midrst_held", 32'h0);
        @(negedge CLK);
        RESET = 1'b1;
        #1 check("midrst_release", 32'h0);
        tick(); check("midrst_refetch", 32'h003170B3);
        fetch(32'd12, "post_rst_pc12", 32'h0051E233);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
